// File: rtl/debug_capture_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : debug_capture_fifo_if
//  Purpose  : Bundles the capture input and drain-side signals of
//             debug_capture_fifo.
//  Modports : slave  - the capture FIFO itself
//             master - the environment (receiver front end + consumer)
//  Signals  : clock_recovery, data_rec, capture_en   (capture side)
//             rd_ready, rd_valid, rd_data             (drain side)
//             fill_level, overflow, clear_overflow    (status/control)
//  Option   : DEBUG_CAPTURE_TIMESTAMP_EN widens rd_data by TS_WIDTH bits
//  Revision : 1.0 - initial release
// ============================================================================
interface debug_capture_fifo_if #(
    parameter int DATA_WIDTH = 14,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 16
);
`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
    localparam int c_TS_EN = 1;
`else
    localparam int c_TS_EN = 0;
`endif
    localparam int c_ENTRY_W = DATA_WIDTH + TS_WIDTH * c_TS_EN;
    localparam int c_PW      = $clog2(DEPTH) + 1;

    logic                  clock_recovery;
    logic [DATA_WIDTH-1:0] data_rec;
    logic                  capture_en;
    logic                  rd_ready;
    logic                  rd_valid;
    logic [c_ENTRY_W-1:0]  rd_data;
    logic [c_PW-1:0]       fill_level;
    logic                  overflow;
    logic                  clear_overflow;

    modport slave (
        input  clock_recovery, data_rec, capture_en, rd_ready, clear_overflow,
        output rd_valid, rd_data, fill_level, overflow
    );

    modport master (
        output clock_recovery, data_rec, capture_en, rd_ready, clear_overflow,
        input  rd_valid, rd_data, fill_level, overflow
    );
endinterface
`default_nettype wire

// File: rtl/debug_capture_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : debug_capture_fifo
//  Purpose  : Samples a receiver word on every rising edge of the
//             asynchronous recovered-clock strobe and stores it in a
//             DEPTH-entry first-word-fall-through FIFO in the clock_50
//             domain. Drops on a full FIFO set a sticky overflow flag.
//  Ports    : clock_50 - system clock (rising edge)
//             reset    - asynchronous, active-high
//             bus      - debug_capture_fifo_if.slave (capture strobe/data,
//                        enable, valid/ready drain port, fill level,
//                        overflow flag and its clear)
//  Option   : DEBUG_CAPTURE_TIMESTAMP_EN - store a TS_WIDTH free-running
//             cycle counter with each entry; rd_data becomes {ts, data}
//  Revision : 1.0 - initial release
// ============================================================================
module debug_capture_fifo #(
    parameter int DATA_WIDTH = 14,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 16
) (
    input  wire logic            clock_50,
    input  wire logic            reset,
    debug_capture_fifo_if.slave  bus
);
`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
    localparam int c_TS_EN = 1;
`else
    localparam int c_TS_EN = 0;
`endif
    localparam int c_ENTRY_W = DATA_WIDTH + TS_WIDTH * c_TS_EN;
    localparam int c_AW      = $clog2(DEPTH);
    localparam int c_PW      = c_AW + 1;

    // ------------------------------------------------------------------
    // Strobe synchroniser. All stages reset to 1 so that a strobe that is
    // already high when reset is released is not mistaken for a new edge.
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic w_edge;

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= bus.clock_recovery;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_sync3;

    // ------------------------------------------------------------------
    // Entry assembly
    // ------------------------------------------------------------------
    logic [c_ENTRY_W-1:0] w_wr_entry;

`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] r_ts;

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // The counter value of the edge cycle is what gets written.
    assign w_wr_entry = {r_ts, bus.data_rec};
`else
    assign w_wr_entry = bus.data_rec;
`endif

    // ------------------------------------------------------------------
    // FIFO control. Pointers carry one extra wrap bit so that full and
    // empty are distinguishable without a separate counter.
    // ------------------------------------------------------------------
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic            r_overflow;
    logic            w_empty;
    logic            w_full;
    logic            w_push_req;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                        (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push_req = w_edge & bus.capture_en;
    assign w_pop      = ~w_empty & bus.rd_ready;
    // A full FIFO still accepts a word when the head is leaving this cycle;
    // the freed slot is the one being written.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Set wins over clear so a drop is never lost.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage. Not reset: contents are only observable through rd_valid,
    // which the pointer reset already forces low.
    // ------------------------------------------------------------------
    logic [c_ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clock_50) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. No write-to-read bypass: a word pushed into an empty FIFO
    // appears on the cycle after the write.
    // ------------------------------------------------------------------
    assign bus.rd_valid   = ~w_empty;
    assign bus.rd_data    = r_mem[r_rd_ptr[c_AW-1:0]];
    assign bus.fill_level = r_wr_ptr - r_rd_ptr;
    assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_debug_capture_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_debug_capture_fifo
//  Purpose  : Self-checking bench for debug_capture_fifo: a table of
//             strobe vectors plus hand-written multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_debug_capture_fifo;
    localparam int c_DW = 14;
    localparam int c_TW = 16;

    logic clock_50 = 1'b0;
    logic reset    = 1'b1;

    debug_capture_fifo_if #(.DATA_WIDTH(c_DW), .DEPTH(16), .TS_WIDTH(c_TW)) bus ();

    debug_capture_fifo #(.DATA_WIDTH(c_DW), .DEPTH(16), .TS_WIDTH(c_TW)) dut (
        .clock_50 (clock_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clock_50 = ~clock_50;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [c_DW-1:0] data;
        logic            en;
        logic [4:0]      fill;
        logic            ovf;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_50);
            #1;
        end
    endtask

    // One strobe: 2 cycles high, 2 low. Called just after a clock edge E;
    // the write happens at edge E+3. rdy/clr are applied only in the
    // cycle that ends with the write edge.
    task automatic strobe(input logic [c_DW-1:0] d, input logic rdy, input logic clr);
        bus.data_rec       = d;
        bus.clock_recovery = 1'b1;
        tick(2);
        bus.clock_recovery = 1'b0;
        bus.rd_ready       = rdy;
        bus.clear_overflow = clr;
        tick(1);
        bus.rd_ready       = 1'b0;
        bus.clear_overflow = 1'b0;
        tick(1);
    endtask

    task automatic pop_one();
        bus.rd_ready = 1'b1;
        tick(1);
        bus.rd_ready = 1'b0;
    endtask

`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
    logic [c_TW-1:0] ts_a;
    logic [c_TW-1:0] ts_b;
    int              delta;
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.clock_recovery = 1'b0;
        bus.data_rec       = '0;
        bus.capture_en     = 1'b1;
        bus.rd_ready       = 1'b0;
        bus.clear_overflow = 1'b0;

        // Vector table: 3 gated strobes, 16 captures, 1 drop on full.
        vecs[0] = '{14'h0155, 1'b0, 5'd0, 1'b0};
        vecs[1] = '{14'h02AA, 1'b0, 5'd0, 1'b0};
        vecs[2] = '{14'h3FFF, 1'b0, 5'd0, 1'b0};
        for (int i = 0; i < 16; i++) begin
            vecs[3+i] = '{c_DW'(i), 1'b1, 5'(i + 1), 1'b0};
        end
        vecs[19] = '{14'h3FFF, 1'b1, 5'd16, 1'b1};

        tick(3);
        reset = 1'b0;
        tick(1);
        chk("reset_valid", 32'(bus.rd_valid), 0);
        chk("reset_fill", 32'(bus.fill_level), 0);
        chk("reset_ovf", 32'(bus.overflow), 0);

        // Single capture with latency check: rise sampled at edge N,
        // rd_valid high only after edge N+2.
        bus.data_rec       = 14'h02A5;
        bus.clock_recovery = 1'b1;
        tick(1);
        chk("lat_n", 32'(bus.rd_valid), 0);
        tick(1);
        chk("lat_n1", 32'(bus.rd_valid), 0);
        bus.clock_recovery = 1'b0;
        tick(1);
        chk("lat_n2", 32'(bus.rd_valid), 1);
        chk("single_data", 32'(bus.rd_data[c_DW-1:0]), 32'h2A5);
        chk("single_fill", 32'(bus.fill_level), 1);
        tick(1);
        pop_one();
        chk("single_pop_valid", 32'(bus.rd_valid), 0);
        chk("single_pop_fill", 32'(bus.fill_level), 0);

        // Table-driven fill, gating and overflow.
        for (int i = 0; i < 20; i++) begin
            bus.capture_en = vecs[i].en;
            strobe(vecs[i].data, 1'b0, 1'b0);
            chk($sformatf("vec%0d_fill", i), 32'(bus.fill_level), 32'(vecs[i].fill));
            chk($sformatf("vec%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].ovf));
            if (vecs[i].fill != 0) begin
                chk($sformatf("vec%0d_head", i), 32'(bus.rd_data[c_DW-1:0]), 0);
            end
        end
        bus.capture_en = 1'b1;

        // Drop together with clear: set dominates.
        strobe(14'h1111, 1'b0, 1'b1);
        chk("drop_clr_ovf", 32'(bus.overflow), 1);
        chk("drop_clr_fill", 32'(bus.fill_level), 16);
        bus.clear_overflow = 1'b1;
        tick(1);
        bus.clear_overflow = 1'b0;
        chk("clear_alone_ovf", 32'(bus.overflow), 0);

        // Contents unchanged by the drops, read in order.
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_valid", i), 32'(bus.rd_valid), 1);
            chk($sformatf("drain%0d_data", i), 32'(bus.rd_data[c_DW-1:0]), 32'(i));
            pop_one();
        end
        chk("drain_empty", 32'(bus.rd_valid), 0);
        chk("drain_fill", 32'(bus.fill_level), 0);

        // Full with a pop in the write cycle: push accepted.
        for (int i = 0; i < 16; i++) begin
            strobe(14'h0100 + c_DW'(i), 1'b0, 1'b0);
        end
        chk("refill_fill", 32'(bus.fill_level), 16);
        strobe(14'h2222, 1'b1, 1'b0);
        chk("fullpop_fill", 32'(bus.fill_level), 16);
        chk("fullpop_ovf", 32'(bus.overflow), 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fullpop%0d_data", i), 32'(bus.rd_data[c_DW-1:0]),
                (i == 15) ? 32'h2222 : 32'h101 + 32'(i));
            pop_one();
        end
        chk("fullpop_empty", 32'(bus.rd_valid), 0);

        // Asynchronous reset with 5 entries stored.
        for (int i = 0; i < 5; i++) begin
            strobe(14'h0030 + c_DW'(i), 1'b0, 1'b0);
        end
        chk("pre_reset_fill", 32'(bus.fill_level), 5);
        reset = 1'b1;
        #1;
        chk("async_reset_fill", 32'(bus.fill_level), 0);
        chk("async_reset_valid", 32'(bus.rd_valid), 0);

        // Strobe held high through reset release: no capture.
        bus.clock_recovery = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(4);
        bus.clock_recovery = 1'b0;
        tick(4);
        chk("held_strobe_fill", 32'(bus.fill_level), 0);
        chk("held_strobe_valid", 32'(bus.rd_valid), 0);

`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
        // Write edges 10 cycles apart.
        strobe(14'h0011, 1'b0, 1'b0);
        tick(6);
        strobe(14'h0022, 1'b0, 1'b0);
        ts_a = bus.rd_data[c_DW+c_TW-1:c_DW];
        pop_one();
        ts_b = bus.rd_data[c_DW+c_TW-1:c_DW];
        pop_one();
        chk("ts_delta", 32'(ts_b - ts_a), 10);

        // Second write lands 3 counts past the wrap.
        strobe(14'h0033, 1'b0, 1'b0);
        ts_a  = bus.rd_data[c_DW+c_TW-1:c_DW];
        delta = 65536 - int'(ts_a) + 3;
        tick(delta - 4);
        strobe(14'h0044, 1'b0, 1'b0);
        pop_one();
        chk("ts_wrap_data", 32'(bus.rd_data[c_DW-1:0]), 32'h44);
        chk("ts_wrap", 32'(bus.rd_data[c_DW+c_TW-1:c_DW]), 3);
        pop_one();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
